// File: rtl/fetch_unit_pkg.sv
// Shared rv32i core definitions: PC-op codes, fetch FSM states, NOP encoding.
// The HALT state exists only when FETCH_MISALIGN_TRAP_EN is defined.
package fetch_unit_pkg;

  typedef enum logic [2:0] {
    PcIncr   = 3'd0,
    PcJAL    = 3'd1,
    PcJALR   = 3'd2,
    PcBranch = 3'd3
  } pc_op_e;

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_RESP  = 3'd1,
    S_ISSUE = 3'd2,
`ifdef FETCH_MISALIGN_TRAP_EN
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
`else
    S_EXEC  = 3'd3
`endif
  } fu_state_e;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC adder/mux. Without FETCH_MISALIGN_TRAP_EN the target is
// word-aligned by force and misaligned_o is constant 0.
module pc_next
  import fetch_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] raw;

  always_comb begin
    raw = pc_i + XLEN'(4);
    case (op_i)
      PcJAL, PcBranch: raw = pc_i + imm_i;
      PcJALR:          raw = (rs1_i + imm_i) & ~XLEN'(1);
      default:         raw = pc_i + XLEN'(4);
    endcase
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  assign next_pc_o    = raw;
  assign misaligned_o = raw[1];
`else
  assign next_pc_o    = {raw[XLEN-1:2], 2'b00};
  assign misaligned_o = 1'b0;
`endif

endmodule

// File: rtl/fetch_unit.sv
// rv32i multi-cycle fetch unit: PC, one imem read per instruction, decode issue,
// wait for retire. Optional misaligned-target trap via FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [2:0]      i_fu_pc_op_data,
  input  logic [XLEN-1:0] i_fu_imm,
  input  logic [XLEN-1:0] i_fu_rs1_data,
  input  logic            i_eu_retire,
  output logic            o_im_arvalid,
  input  logic            i_im_arready,
  output logic [XLEN-1:0] o_im_araddr,
  input  logic            i_im_rvalid,
  output logic            o_im_rready,
  input  logic [31:0]     i_im_rdata,
  output logic            o_du_inst_valid,
  input  logic            i_du_inst_ready,
  output logic [31:0]     o_du_inst,
  output logic [XLEN-1:0] o_du_pc,
  output logic            o_fu_misaligned
);

  fu_state_e       state_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q;
  logic            misaligned;

  pc_next #(.XLEN(XLEN)) u_pc_next (
    .pc_i         (pc_q),
    .op_i         (i_fu_pc_op_data),
    .imm_i        (i_fu_imm),
    .rs1_i        (i_fu_rs1_data),
    .next_pc_o    (pc_d),
    .misaligned_o (misaligned)
  );

`ifdef FETCH_MISALIGN_TRAP_EN
  logic mis_q;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= INST_NOP;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_REQ:   if (i_im_arready) state_q <= S_RESP;
        S_RESP:  if (i_im_rvalid) begin
                   inst_q  <= i_im_rdata;
                   state_q <= S_ISSUE;
                 end
        S_ISSUE: if (i_du_inst_ready) state_q <= S_EXEC;
        S_EXEC:  if (i_eu_retire) begin
                   pc_q <= pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
                   // The faulting target is kept in the PC for inspection.
                   if (misaligned) begin
                     mis_q   <= 1'b1;
                     state_q <= S_HALT;
                   end else begin
                     state_q <= S_REQ;
                   end
`else
                   state_q <= S_REQ;
`endif
                 end
        default: state_q <= state_q;
      endcase
    end
  end

  assign o_im_arvalid    = (state_q == S_REQ);
  assign o_im_rready     = (state_q == S_RESP);
  assign o_du_inst_valid = (state_q == S_ISSUE);
  assign o_im_araddr     = pc_q;
  assign o_du_pc         = pc_q;
  assign o_du_inst       = inst_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign o_fu_misaligned = mis_q;
`else
  assign o_fu_misaligned = misaligned;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: transaction-level model compared every cycle,
// plus literal expectations from hand-computed PC sequences.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, retire, arready, rvalid, du_ready;
  logic [2:0]  op;
  logic [31:0] imm, rs1, rdata;
  logic        arvalid, rready, du_valid, mis;
  logic [31:0] araddr, du_inst, du_pc;

  fetch_unit #(.XLEN(32), .RESET_PC(RPC)) dut (
    .i_clk(clk), .i_rst(rst), .i_fu_pc_op_data(op), .i_fu_imm(imm),
    .i_fu_rs1_data(rs1), .i_eu_retire(retire),
    .o_im_arvalid(arvalid), .i_im_arready(arready), .o_im_araddr(araddr),
    .i_im_rvalid(rvalid), .o_im_rready(rready), .i_im_rdata(rdata),
    .o_du_inst_valid(du_valid), .i_du_inst_ready(du_ready),
    .o_du_inst(du_inst), .o_du_pc(du_pc), .o_fu_misaligned(mis)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int ar_hs = 0, du_hs = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which transaction the unit is waiting on, plus architectural PC.
  // 0 = address, 1 = data, 2 = decode accept, 3 = retire, 4 = halted
  int          m_wait;
  logic [31:0] m_pc, m_inst;
  logic        m_mis;

  function automatic logic [31:0] target(input logic [31:0] pc, input logic [2:0] o,
                                         input logic [31:0] i, input logic [31:0] r);
    logic [31:0] t;
    if (o == 3'd1 || o == 3'd3) t = pc + i;
    else if (o == 3'd2)         t = (r + i) & 32'hFFFF_FFFE;
    else                        t = pc + 32'd4;
    return t;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_wait = 0; m_pc = RPC; m_inst = 32'h13; m_mis = 0; chk_en = 1;
    end else if (m_wait == 0 && arready) m_wait = 1;
    else if (m_wait == 1 && rvalid) begin m_inst = rdata; m_wait = 2; end
    else if (m_wait == 2 && du_ready) m_wait = 3;
    else if (m_wait == 3 && retire) begin
      m_pc = target(m_pc, op, imm, rs1);
`ifdef FETCH_MISALIGN_TRAP_EN
      if (m_pc[1]) begin m_mis = 1; m_wait = 4; end else m_wait = 0;
`else
      m_pc[1:0] = 2'b00; m_wait = 0;
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("arvalid", {31'd0, arvalid}, {31'd0, m_wait == 0});
      chk("rready", {31'd0, rready}, {31'd0, m_wait == 1});
      chk("inst_valid", {31'd0, du_valid}, {31'd0, m_wait == 2});
      chk("araddr", araddr, m_pc);
      chk("du_pc", du_pc, m_pc);
      chk("du_inst", du_inst, m_inst);
      chk("misaligned", {31'd0, mis}, {31'd0, m_mis});
      if (arvalid && arready) ar_hs++;
      if (du_valid && du_ready) du_hs++;
    end
  end

  task automatic fetch(input logic [31:0] data, input int ar_wait, input int du_wait);
    arready = 0; repeat (ar_wait) @(negedge clk);
    arready = 1; @(negedge clk); arready = 0;
    rvalid = 1; rdata = data; @(negedge clk); rvalid = 0;
    du_ready = 0; repeat (du_wait) @(negedge clk);
    du_ready = 1; @(negedge clk); du_ready = 0;
  endtask

  task automatic do_retire(input logic [2:0] o, input logic [31:0] i, input logic [31:0] r);
    op = o; imm = i; rs1 = r; retire = 1; @(negedge clk); retire = 0;
  endtask

  initial begin
    int n, a0, d0;
    rst = 1; retire = 0; arready = 0; rvalid = 0; du_ready = 0;
    op = 0; imm = 0; rs1 = 0; rdata = 0;
    repeat (2) @(negedge clk);
    rst = 0; @(negedge clk);
    chk("rst_arvalid", {31'd0, arvalid}, 32'd1);
    chk("rst_araddr", araddr, 32'h100);
    chk("rst_inst_valid", {31'd0, du_valid}, 32'd0);
    chk("rst_du_inst", du_inst, 32'h13);

    // sequential fetch and best-case loop latency
    fetch(32'h0050_0093, 0, 0);
    chk("seq_du_inst", du_inst, 32'h0050_0093);
    chk("seq_du_pc", du_pc, 32'h100);
    arready = 1; rvalid = 1; rdata = 32'h0000_0113;
    do_retire(3'd0, 0, 0);
    n = 1;
    while (!du_valid && n < 10) begin @(negedge clk); n++; end
    chk("loop_latency", n, 3);
    chk("seq_next_pc", du_pc, 32'h104);
    arready = 0; rvalid = 0; du_ready = 1; @(negedge clk); du_ready = 0;

    // backpressure on both handshakes
    do_retire(3'd1, 32'h0000_00FC, 0);
    chk("jal_fwd", araddr, 32'h200);
    a0 = ar_hs; d0 = du_hs;
    fetch(32'h1234_5678, 5, 4);
    chk("bp_ar_hs", ar_hs - a0, 1);
    chk("bp_du_hs", du_hs - d0, 1);

    do_retire(3'd1, 32'hFFFF_FFF0, 0);
    chk("jal_back", araddr, 32'h1F0);
    fetch(32'h0, 0, 0);
    do_retire(3'd2, 32'd4, 32'h301);
    chk("jalr", araddr, 32'h304);
    fetch(32'h0, 1, 0);
    do_retire(3'd2, 32'd4, 32'hFFFF_FFF8);
    chk("jalr_top", araddr, 32'hFFFF_FFFC);
    fetch(32'h0, 0, 2);
    do_retire(3'd0, 0, 0);
    chk("wrap", araddr, 32'h0);
    fetch(32'h0, 0, 0);
    do_retire(3'd3, 32'd6, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_flag", {31'd0, mis}, 32'd1);
    arready = 1; rvalid = 1; du_ready = 1;
    n = 0;
    repeat (4) begin @(negedge clk); n += int'(arvalid); end
    chk("halt_no_fetch", n, 0);
    arready = 0; rvalid = 0; du_ready = 0;
    rst = 1; @(negedge clk); rst = 0; @(negedge clk);
`else
    chk("mis_aligned", araddr, 32'h4);
    chk("mis_flag0", {31'd0, mis}, 32'd0);
    fetch(32'h0, 0, 0);
    do_retire(3'd6, 32'h40, 0);
    chk("undef_op", araddr, 32'h8);
`endif

    // reset mid-fetch, with a simultaneous stray retire
    arready = 1; @(negedge clk); arready = 0;
    chk("resp_rready", {31'd0, rready}, 32'd1);
    rst = 1; retire = 1; @(negedge clk); rst = 0; retire = 0;
    chk("rst_mid_arvalid", {31'd0, arvalid}, 32'd1);
    chk("rst_mid_araddr", araddr, RPC);
    chk("rst_mid_rready", {31'd0, rready}, 32'd0);
    fetch(32'h0000_0073, 0, 0);
    chk("after_rst_inst", du_inst, 32'h0000_0073);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
